// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter
//   Shared W-bit counter driven by NREQ requesters through a round-robin
//   arbiter. Each requester issues CLR/INC/DEC/LOAD. A free-running prescaler
//   produces autocount ticks that increment the counter when enabled.
//   Registered edge triggers flag arrival at zero, all-ones and THRESH.
//
// Optional feature macro: COUNTER_CMD_SAT_EN
//   Defined:   INC and autocount saturate at all-ones, DEC saturates at zero.
//   Undefined: INC/DEC/autocount wrap modulo 2^W.
//
// Ports
//   clk           in   block clock, posedge
//   reset_n       in   asynchronous active-low reset
//   req[NREQ]     in   per-requester request, held until its ack
//   cmd[2*NREQ]   in   cmd[2i+:2] for requester i: 00 CLR, 01 INC, 10 DEC, 11 LOAD
//   data[W*NREQ]  in   data[W*i+:W] load value for requester i
//   ack[NREQ]     out  one-hot grant-complete pulse, high during the EXEC cycle
//   autocount_en  in   enables prescaler-tick increments
//   count[W]      out  registered counter value
//   busy          out  FSM state bit: high while in EXEC
//   trig_zero     out  1-cycle pulse when count has just become 0
//   trig_max      out  1-cycle pulse when count has just become all-ones
//   trig_thresh   out  1-cycle pulse when count has just become THRESH
//
// Handshake: in IDLE the arbiter samples req and, for the winner, latches
// cmd/data on the IDLE->EXEC edge; the requester may change cmd/data after
// that edge. ack[winner] is high for the whole EXEC cycle and the requester
// drops req on the clock edge that ends that cycle. A req still high in the
// following IDLE cycle is a new request.
module counter_cmd_arbiter #(
    parameter int             NREQ   = 4,
    parameter int             W      = 8,
    parameter int             DIV    = 4194304,
    parameter logic [W-1:0]   THRESH = 8'h80
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   cmd,
    input  logic [W*NREQ-1:0]   data,
    output logic [NREQ-1:0]     ack,
    input  logic                autocount_en,
    output logic [W-1:0]        count,
    output logic                busy,
    output logic                trig_zero,
    output logic                trig_max,
    output logic                trig_thresh
);

    localparam int              PTRW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              PW        = $clog2(DIV);
    localparam logic [PTRW:0]   NREQ_L    = (PTRW+1)'(NREQ);
    localparam logic [PW-1:0]   PRESC_TOP = PW'(DIV - 1);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t             state, state_next;
    logic [PTRW-1:0]    rr_ptr;
    logic [PTRW-1:0]    win_idx;
    logic [NREQ-1:0]    win_oh;
    logic [1:0]         cmd_q;
    logic [W-1:0]       data_q;
    logic [PW-1:0]      presc;
    logic               tick;
    logic               tick_pend, pend_next;

    logic               grant_found;
    logic [PTRW-1:0]    grant_idx;
    logic [NREQ-1:0]    grant_oh;
    logic [1:0]         grant_cmd;
    logic [W-1:0]       grant_data;
    logic [PTRW:0]      cand;
    logic [PTRW:0]      rr_inc;

    logic [W-1:0]       inc_val, dec_val, exec_val, count_next;

    // Rotating-priority search starting at rr_ptr. The extra bit of cand
    // lets the modulo-NREQ wrap work for non-power-of-two NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        cand        = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, rr_ptr} + (PTRW+1)'(off);
            if (cand >= NREQ_L) cand = cand - NREQ_L;
            if (!grant_found && req[cand[PTRW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTRW-1:0];
            end
        end
        grant_oh[grant_idx] = grant_found;
    end

    always_comb begin
        grant_cmd  = '0;
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                grant_cmd  = cmd[2*i +: 2];
                grant_data = data[W*i +: W];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rr_inc = {1'b0, win_idx} + (PTRW+1)'(1);
        if (rr_inc == NREQ_L) rr_inc = '0;
    end

`ifdef COUNTER_CMD_SAT_EN
    assign inc_val = (count == {W{1'b1}}) ? count : count + W'(1);
    assign dec_val = (count == '0)        ? count : count - W'(1);
`else
    assign inc_val = count + W'(1);
    assign dec_val = count - W'(1);
`endif

    assign tick = (presc == '0);

    // EXEC owns the count update in its cycle; a tick landing on EXEC is
    // parked in tick_pend and applied in the next non-EXEC cycle. Only one
    // tick can be parked, and dropping autocount_en discards it.
    always_comb begin
        case (cmd_q)
            2'b00:   exec_val = '0;
            2'b01:   exec_val = inc_val;
            2'b10:   exec_val = dec_val;
            default: exec_val = data_q;
        endcase
        count_next = count;
        pend_next  = autocount_en ? tick_pend : 1'b0;
        if (state == EXEC) begin
            count_next = exec_val;
            if (autocount_en && tick) pend_next = 1'b1;
        end else if (autocount_en && (tick || tick_pend)) begin
            count_next = inc_val;
            pend_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win_idx     <= '0;
            win_oh      <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            presc       <= PRESC_TOP;
            tick_pend   <= 1'b0;
            count       <= '0;
            trig_zero   <= 1'b0;
            trig_max    <= 1'b0;
            trig_thresh <= 1'b0;
        end else begin
            state       <= state_next;
            presc       <= tick ? PRESC_TOP : presc - PW'(1);
            tick_pend   <= pend_next;
            count       <= count_next;
            // Pulse only on a real change into the match value.
            trig_zero   <= (count_next != count) && (count_next == '0);
            trig_max    <= (count_next != count) && (count_next == {W{1'b1}});
            trig_thresh <= (count_next != count) && (count_next == THRESH);
            if (state == IDLE && grant_found) begin
                win_idx <= grant_idx;
                win_oh  <= grant_oh;
                cmd_q   <= grant_cmd;
                data_q  <= grant_data;
            end
            if (state == EXEC) rr_ptr <= rr_inc[PTRW-1:0];
        end
    end

    assign busy = (state == EXEC);
    assign ack  = busy ? win_oh : '0;

endmodule
